// File: rtl/ram_multitap_line_shifter.sv
// rtl/ram_multitap_line_shifter.sv - RAM-backed multi-tap line shifter, tap k = input delayed k*D beats
// Optional zero padding of unfilled taps: define RSLS_ZERO_FILL_EN.
module ram_multitap_line_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TAP_NUM    = 2
) (
  input  logic                              system_clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic [ADDR_WIDTH-1:0]             shift_size,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              out_valid,
  output logic [(TAP_NUM+1)*DATA_WIDTH-1:0] out_data,
  output logic [TAP_NUM-1:0]                tap_live,
  output logic                              fill_done,
  output logic                              cfg_err
);

  localparam int CW    = ADDR_WIDTH + 3;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t                            state, state_nxt;
  logic [ADDR_WIDTH-1:0]             d_lat, d_cur, wr_addr, rd_addr;
  logic [CW-1:0]                     cnt, n_cur, n_nxt, fill_thr;
  logic                              beat, start_bad, bypass;
  logic [TAP_NUM-1:0]                live_nxt;
  logic [TAP_NUM:0][DATA_WIDTH-1:0]  taps;

  always_comb begin
    d_cur     = (state == IDLE) ? shift_size : d_lat;
    beat      = in_valid && !clear && (state != IDLE || shift_size != '0);
    start_bad = in_valid && !clear && state == IDLE && shift_size == '0;
    n_cur     = (state == IDLE) ? '0 : cnt;
    fill_thr  = CW'(TAP_NUM) * CW'(d_cur);
    n_nxt     = (n_cur >= fill_thr) ? fill_thr : n_cur + CW'(1);
    for (int k = 0; k < TAP_NUM; k++)
      live_nxt[k] = tap_live[k] | (n_cur >= CW'(k + 1) * CW'(d_cur));
    // Entry at address a holds the previous beat's tap, so reading a-D+1 yields x[n-D].
    rd_addr   = wr_addr - d_cur + ADDR_WIDTH'(1);
    bypass    = (d_cur == ADDR_WIDTH'(1));
    state_nxt = state;
    if (beat)
      state_nxt = (&live_nxt) ? FULL : RUN;
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d_lat     <= '0;
      wr_addr   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      tap_live  <= '0;
      fill_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      wr_addr   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      tap_live  <= '0;
      fill_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      out_valid <= beat;
      if (start_bad)
        cfg_err <= 1'b1;
      if (beat) begin
        state     <= state_nxt;
        d_lat     <= d_cur;
        wr_addr   <= wr_addr + ADDR_WIDTH'(1);
        cnt       <= n_nxt;
        tap_live  <= live_nxt;
        fill_done <= &live_nxt;
      end
    end
  end

  logic [DATA_WIDTH-1:0] tap0_q;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst)
      tap0_q <= '0;
    else if (beat)
      tap0_q <= in_data;
  end

  assign taps[0] = tap0_q;

  for (genvar k = 1; k <= TAP_NUM; k++) begin : g_tap
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] q;

    always_ff @(posedge system_clk) begin
      if (beat)
        mem[wr_addr] <= taps[k-1];
    end

    // With D=1 the wanted word is written this same beat, so take it from the previous tap register.
    assign rd_word = bypass ? taps[k-1] : mem[rd_addr];

    always_ff @(posedge system_clk or posedge rst) begin
      if (rst)
        q <= '0;
      else if (beat)
`ifdef RSLS_ZERO_FILL_EN
        q <= live_nxt[k-1] ? rd_word : '0;
`else
        q <= rd_word;
`endif
    end

    assign taps[k] = q;
  end

  assign out_data = taps;

endmodule

// File: tb/tb_ram_multitap_line_shifter.sv
// tb/tb_ram_multitap_line_shifter.sv - directed table-driven bench for ram_multitap_line_shifter
module tb_ram_multitap_line_shifter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TN = 2;

  logic                 system_clk = 1'b0;
  logic                 rst, clear, in_valid;
  logic [AW-1:0]        shift_size;
  logic [DW-1:0]        in_data;
  logic                 out_valid, fill_done, cfg_err;
  logic [(TN+1)*DW-1:0] out_data;
  logic [TN-1:0]        tap_live;

  int tests = 0;
  int fails = 0;

  ram_multitap_line_shifter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAP_NUM(TN)) dut (
    .system_clk(system_clk), .rst(rst), .clear(clear), .shift_size(shift_size),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .tap_live(tap_live), .fill_done(fill_done), .cfg_err(cfg_err)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    int            beat;
    logic [DW-1:0] t0, t1, t2;
    logic [TN-1:0] live;
    logic          fill;
  } vec_t;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  task automatic beat(logic v, logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  function automatic logic [(TN+1)*DW-1:0] tap_mask(logic [TN-1:0] lv);
    logic [(TN+1)*DW-1:0] m;
    m = '0;
    m[DW-1:0] = '1;
    for (int k = 1; k <= TN; k++) begin
`ifdef RSLS_ZERO_FILL_EN
      m[k*DW +: DW] = '1;
`else
      if (lv[k-1]) m[k*DW +: DW] = '1;
`endif
    end
    return m;
  endfunction

  // Model: tap k at beat n of a stream x[i]=base+i is base+n-k*D once n >= k*D, else zero/ignored.
  task automatic check_beat(string name, int n, int d, logic [DW-1:0] base);
    logic [TN-1:0]        lv;
    logic [(TN+1)*DW-1:0] ed;
    ed = '0;
    ed[DW-1:0] = base + DW'(n);
    for (int k = 1; k <= TN; k++) begin
      lv[k-1] = (n >= k * d);
      if (lv[k-1]) ed[k*DW +: DW] = base + DW'(n - k * d);
    end
    chk($sformatf("%s n=%0d", name, n),
        {out_valid, fill_done, tap_live, out_data & tap_mask(lv)},
        {1'b1, &lv, lv, ed});
  endtask

  task automatic run_table(string name);
    vec_t vt[7];
    int   n;
    vt[0] = '{0,  32'd1,  32'd0, 32'd0, 2'b00, 1'b0};
    vt[1] = '{3,  32'd4,  32'd0, 32'd0, 2'b00, 1'b0};
    vt[2] = '{4,  32'd5,  32'd1, 32'd0, 2'b01, 1'b0};
    vt[3] = '{7,  32'd8,  32'd4, 32'd0, 2'b01, 1'b0};
    vt[4] = '{8,  32'd9,  32'd5, 32'd1, 2'b11, 1'b1};
    vt[5] = '{9,  32'd10, 32'd6, 32'd2, 2'b11, 1'b1};
    vt[6] = '{12, 32'd13, 32'd9, 32'd5, 2'b11, 1'b1};
    shift_size = 10'd4;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      while (n <= vt[i].beat) begin
        beat(1'b1, DW'(n + 1));
        n++;
      end
      chk($sformatf("%s beat %0d", name, vt[i].beat),
          {out_valid, fill_done, tap_live, out_data & tap_mask(vt[i].live)},
          {1'b1, vt[i].fill, vt[i].live, {vt[i].t2, vt[i].t1, vt[i].t0} & tap_mask(vt[i].live)});
    end
  endtask

  initial begin
    logic [(TN+1)*DW-1:0] held;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; shift_size = 10'd4;
    #12;
    chk("reset", {out_valid, fill_done, cfg_err, tap_live, out_data}, '0);
    @(negedge system_clk);
    rst = 1'b0;
    step();

    run_table("t1");

    do_clear();
    chk("clear state", {out_valid, fill_done, cfg_err, tap_live}, '0);
    shift_size = 10'd4;
    for (int n = 0; n <= 12; n++) begin
      beat(1'b1, DW'(n + 1));
      check_beat("t2 toggled", n, 4, 32'd1);
      held = out_data;
      beat(1'b0, 32'hdead_beef);
      chk($sformatf("t2 stall n=%0d", n), {out_valid, out_data}, {1'b0, held});
    end

    do_clear();
    shift_size = 10'd1023;
    for (int n = 0; n < 3000; n++) begin
      beat(1'b1, 32'h1000 + DW'(n));
      if (n % 8 == 0 || (n >= 2040 && n <= 2050) || (n >= 1020 && n <= 1030))
        check_beat("t3 D=1023", n, 1023, 32'h1000);
    end

    do_clear();
    shift_size = 10'd1;
    for (int n = 0; n < 6; n++) begin
      beat(1'b1, 32'd100 + DW'(n));
      check_beat("D=1", n, 1, 32'd100);
    end

    do_clear();
    shift_size = 10'd0;
    for (int n = 0; n < 3; n++) begin
      beat(1'b1, DW'(n));
      chk($sformatf("D=0 n=%0d", n), {cfg_err, out_valid, tap_live}, {1'b1, 1'b0, 2'b00});
    end
    do_clear();
    chk("cfg_err cleared", {cfg_err}, 1'b0);

    shift_size = 10'd4;
    for (int n = 0; n < 6; n++) begin
      beat(1'b1, 32'd200 + DW'(n));
      shift_size = 10'd7;
      check_beat("t4 first", n, 4, 32'd200);
    end
    clear = 1'b1; in_valid = 1'b1; in_data = 32'd206;
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("t4 clear+valid", {out_valid, fill_done, tap_live}, '0);
    shift_size = 10'd2;
    for (int n = 0; n <= 4; n++) begin
      beat(1'b1, 32'd300 + DW'(n));
      check_beat("t4 second", n, 2, 32'd300);
    end

    do_clear();
    shift_size = 10'd4;
    for (int n = 0; n <= 5; n++) begin
      beat(1'b1, DW'(n + 1));
      check_beat("t5 pre", n, 4, 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk("t5 async reset", {out_valid, fill_done, cfg_err, tap_live, out_data}, '0);
    #1 rst = 1'b0;
    run_table("t5 refill");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
